// File: rtl/dq_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dq_flush_ctrl
// Purpose  : Front-end flush/redirect sequencer. Turns syscall and branch
//            mispredict events from ID into an ordered flush of the decode
//            queue, an IF/ID stall while the pipe drains, and a held redirect
//            PC handed to IF's PC-select logic.
// Revision : 1.0 - initial release
// ============================================================================
module dq_flush_ctrl #(
  parameter int          DRAIN_CYCLES   = 2,            // legal range 1..15
  parameter logic [31:0] SYSCALL_VECTOR = 32'h8000_0180
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        SYS_REQ,
  input  logic        MISPRED_REQ,
  input  logic [31:0] MISPRED_PC,
  input  logic        IF_READY,
  output logic        DQ_FLUSH,
  output logic        STALL_IF,
  output logic        STALL_ID,
  output logic        REDIRECT_VALID,
  output logic [31:0] REDIRECT_PC,
  output logic        CAUSE_SYS,
  output logic [15:0] FLUSH_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  // Counter reload: DRAIN is left when the counter has reached zero, so
  // loading DRAIN_CYCLES-1 gives exactly DRAIN_CYCLES cycles in DRAIN.
  localparam logic [3:0]  c_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [15:0] c_COUNT_MAX  = 16'hFFFF;

  state_t      r_state;
  logic [31:0] r_target;
  logic        r_cause_sys;
  logic [3:0]  r_cnt;
  logic [15:0] r_flush_count;

  state_t      w_state_nxt;
  logic [31:0] w_target_nxt;
  logic        w_cause_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [15:0] w_count_nxt;
  logic        w_start;

  // Next-state, target latch, drain counter and flush counter update.
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_cause_nxt  = r_cause_sys;
    w_cnt_nxt    = r_cnt;
    w_count_nxt  = r_flush_count;
    w_start      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Syscall has priority; a simultaneous mispredict is dropped.
        if (SYS_REQ) begin
          w_target_nxt = SYSCALL_VECTOR;
          w_cause_nxt  = 1'b1;
          w_state_nxt  = ST_FLUSH;
          w_start      = 1'b1;
        end else if (MISPRED_REQ) begin
          w_target_nxt = MISPRED_PC;
          w_cause_nxt  = 1'b0;
          w_state_nxt  = ST_FLUSH;
          w_start      = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_cnt_nxt   = c_DRAIN_LOAD;
        w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_REDIRECT;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_REDIRECT: begin
        if (IF_READY) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A syscall arriving during a mispredict sequence restarts the whole
    // sequence toward the syscall vector; anything else mid-sequence is lost.
    if ((r_state != ST_IDLE) && SYS_REQ && !r_cause_sys) begin
      w_target_nxt = SYSCALL_VECTOR;
      w_cause_nxt  = 1'b1;
      w_state_nxt  = ST_FLUSH;
      w_start      = 1'b1;
    end

    if (w_start && (r_flush_count != c_COUNT_MAX)) begin
      w_count_nxt = r_flush_count + 16'd1;
    end
  end

  // State and datapath registers; reset takes effect without a clock edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= ST_IDLE;
      r_target      <= 32'h0;
      r_cause_sys   <= 1'b0;
      r_cnt         <= 4'd0;
      r_flush_count <= 16'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_target      <= w_target_nxt;
      r_cause_sys   <= w_cause_nxt;
      r_cnt         <= w_cnt_nxt;
      r_flush_count <= w_count_nxt;
    end
  end

  // Outputs decode purely from registered state, never from inputs.
  always_comb begin
    DQ_FLUSH       = (r_state == ST_FLUSH);
    STALL_IF       = (r_state != ST_IDLE);
    STALL_ID       = (r_state != ST_IDLE);
    REDIRECT_VALID = (r_state == ST_REDIRECT);
    REDIRECT_PC    = r_target;
    CAUSE_SYS      = r_cause_sys;
    FLUSH_COUNT    = r_flush_count;
  end

endmodule
`default_nettype wire

// File: doc/dq_flush_ctrl.md
# dq_flush_ctrl

Flush/redirect sequencer for the front end. It takes syscall and branch-mispredict events from ID and produces an ordered sequence: flush the decode queue, stall IF and ID while the pipe drains, then hand a redirect PC to IF. It sits between ID, the decode queue (via its SYS/flush input), and IF's PC-select logic.

## Interface
- DRAIN_CYCLES, 2: cycles spent in DRAIN after the flush pulse; legal range 1–15.
- SYSCALL_VECTOR, 32'h8000_0180: redirect target for a syscall.
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET_N  input  1  reset; asynchronous and active-low.
- SYS_REQ  input  1  ID has decoded a syscall; single-cycle pulse.
- MISPRED_REQ  input  1  branch mispredict detected; single-cycle pulse.
- MISPRED_PC  input  32  correct target, valid with MISPRED_REQ.
- IF_READY  input  1  IF accepts the redirect this cycle.
- DQ_FLUSH  output  1  flush strobe to the decode queue SYS input.
- STALL_IF  output  1  stall to IF (ORed into the DQ STALL_IN_IF path).
- STALL_ID  output  1  stall to ID.
- REDIRECT_VALID  output  1  REDIRECT_PC is valid; held until accepted.
- REDIRECT_PC  output  32  latched redirect target.
- CAUSE_SYS  output  1  latched cause: 1 = syscall, 0 = mispredict.
- FLUSH_COUNT  output  16  number of flush sequences started; saturating.

## Operation
- FSM states: IDLE, FLUSH, DRAIN, REDIRECT. All outputs decode from registered state and registers only. No output path is combinational from an input.
- IDLE
  - All strobes and stalls are 0.
  - If SYS_REQ is high: latch target = SYSCALL_VECTOR, CAUSE_SYS = 1, go to FLUSH.
  - Else if MISPRED_REQ is high: latch target = MISPRED_PC, CAUSE_SYS = 0, go to FLUSH.
  - When both are high, SYS wins and MISPRED is dropped.
- FLUSH
  - DQ_FLUSH = 1, STALL_IF = 1, STALL_ID = 1.
  - Load drain counter = DRAIN_CYCLES − 1.
  - FLUSH_COUNT increments by 1 on entry, holding at 16'hFFFF.
  - Always go to DRAIN next cycle.
- DRAIN
  - STALL_IF = STALL_ID = 1, DQ_FLUSH = 0.
  - The counter decrements each cycle. When the counter is 0, go to REDIRECT.
- REDIRECT
  - REDIRECT_VALID = 1, REDIRECT_PC = latched target, stalls stay 1.
  - On a cycle with IF_READY = 1, go to IDLE.
  - REDIRECT_PC is stable while REDIRECT_VALID is high and not yet accepted.
- Preemption in FLUSH, DRAIN or REDIRECT
  - SYS_REQ while CAUSE_SYS = 0: retarget to SYSCALL_VECTOR, set CAUSE_SYS = 1, restart at FLUSH. FLUSH_COUNT increments again.
  - Any other request is ignored.
- REDIRECT_PC and CAUSE_SYS hold their last values in IDLE.

## Timing
- Reset (RESET_N low, any time, including mid-sequence): state goes to IDLE immediately without waiting for a clock.
  - DQ_FLUSH, STALL_IF, STALL_ID, REDIRECT_VALID, CAUSE_SYS go to 0.
  - REDIRECT_PC goes to 32'h0, FLUSH_COUNT to 16'h0, drain counter to 0.
- Request sampled at edge N: DQ_FLUSH and stalls are high after edge N+1 (the FLUSH cycle). DQ_FLUSH is high for exactly one cycle.
- DRAIN lasts exactly DRAIN_CYCLES cycles.
- REDIRECT_VALID first rises DRAIN_CYCLES + 1 cycles after DQ_FLUSH rises.
- Stall coverage:
  - STALL_IF/STALL_ID are continuous from the FLUSH cycle through the REDIRECT acceptance cycle.
  - They drop in the cycle after the edge that samples IF_READY = 1 in REDIRECT.
- Minimum sequence, DRAIN_CYCLES = 1 and IF_READY held high: FLUSH, DRAIN, REDIRECT, IDLE (3 stalled cycles).
- Back-to-back: a request in the first IDLE cycle after acceptance starts a new sequence with no bubble beyond that IDLE cycle.
- IF_READY outside REDIRECT is ignored.

## Test plan
- **Reset values.** Hold RESET_N low for 3 cycles, then release → all outputs 0, REDIRECT_PC = 0, FLUSH_COUNT = 0.
- **Mispredict, default parameters.** MISPRED_REQ pulse with MISPRED_PC = 32'h0040_0020, IF_READY tied high → next cycle DQ_FLUSH = 1 for one cycle.
  - Stalls high for 4 cycles total.
  - REDIRECT_VALID high for 1 cycle with REDIRECT_PC = 32'h0040_0020, CAUSE_SYS = 0.
  - FLUSH_COUNT = 1.
- **Simultaneous requests.** SYS_REQ and MISPRED_REQ in the same cycle → REDIRECT_PC = 32'h8000_0180, CAUSE_SYS = 1, exactly one flush pulse.
- **Preemption.** Mispredict, then SYS_REQ during DRAIN → second DQ_FLUSH pulse, final REDIRECT_PC = 32'h8000_0180, FLUSH_COUNT = 2. A further MISPRED_REQ during this sequence is ignored.
- **IF backpressure.** Hold IF_READY low for 5 cycles in REDIRECT → REDIRECT_VALID, REDIRECT_PC and stalls held stable. After IF_READY goes high, all drop in the following cycle.
- **Reset mid-sequence.** Drop RESET_N while in DRAIN (asynchronously, between clock edges) → stalls and DQ_FLUSH go to 0 before the next edge. After release, the block is idle with FLUSH_COUNT = 0.
